// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide CPU bus responder for 128KB RAM plus the 0x3xxxx IO window
// (UART TX FIFO, UART RX byte port, cycle counter with coherent snapshot, program-stop flag).
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_done,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0]    ram [2**RAM_AW];
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_din_q, mem_din_d, push_data;
  logic [31:0]   cyc_q, snap_q, snap_d;
  logic          rx_pop_q, prog_done_q, tx_overflow_q;
  logic          io, io_rd_rx, io_rd_cyc, io_rd_snap, io_wr_tx, io_wr_stop;
  logic          push, pop, full, do_push;
  logic          unused_addr;
  assign unused_addr = ^mem_a[31:18];
  assign io         = mem_a[17:16] == 2'b11;
  assign io_rd_rx   = io && !mem_wr && mem_a[15:0] == 16'h0000;
  assign io_rd_cyc  = io && !mem_wr && mem_a[15:0] == 16'h0004;
  assign io_rd_snap = io && !mem_wr && mem_a[15:2] == 14'h0001 && mem_a[1:0] != 2'b00;
  assign io_wr_tx   = io && mem_wr && mem_a[15:0] == 16'h0000 && mem_dout != 8'h00;
  assign io_wr_stop = io && mem_wr && mem_a[15:0] == 16'h0004;
  // The stop marker is a literal zero byte so the UART side can see end-of-program in-band.
  assign push      = io_wr_tx || io_wr_stop;
  assign push_data = io_wr_stop ? 8'h00 : mem_dout;
  assign tx_valid  = count_q != '0;
  assign tx_data   = fifo_q[rd_ptr_q];
  assign pop       = tx_valid && tx_ready;
  assign full      = count_q == CW'(TX_DEPTH);
  assign do_push   = push && (!full || pop);
  assign count_d   = count_q + CW'(do_push) - CW'(pop);
  assign io_buffer_full = (CW'(TX_DEPTH) - count_q) <= CW'(FULL_MARGIN);
  assign mem_din     = mem_din_q;
  assign rx_pop      = rx_pop_q;
  assign prog_done   = prog_done_q;
  assign tx_overflow = tx_overflow_q;
  // Reading the low counter byte captures the whole counter so the upper bytes read back coherently.
  always_comb begin
    mem_din_d = mem_din_q;
    snap_d    = snap_q;
    if (!mem_wr) begin
      if (!io) mem_din_d = ram[mem_a[RAM_AW-1:0]];
      else if (io_rd_rx) mem_din_d = rx_valid ? rx_data : 8'h00;
      else if (io_rd_cyc) begin
        mem_din_d = cyc_q[7:0];
        snap_d    = cyc_q;
      end
      else if (io_rd_snap) mem_din_d = snap_q[{mem_a[1:0], 3'b000} +: 8];
      else mem_din_d = 8'h00;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!io && mem_wr) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (do_push) fifo_q[wr_ptr_q] <= push_data;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din_q     <= '0;
      snap_q        <= '0;
      cyc_q         <= '0;
      rx_pop_q      <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      prog_done_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      mem_din_q     <= mem_din_d;
      snap_q        <= snap_d;
      cyc_q         <= cyc_q + 32'd1;
      rx_pop_q      <= io_rd_rx && rx_valid;
      count_q       <= count_d;
      wr_ptr_q      <= do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q      <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      prog_done_q   <= prog_done_q || io_wr_stop;
      tx_overflow_q <= tx_overflow_q || (push && full && !pop);
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;
  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0, rx_data = '0;
  logic        mem_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, prog_done, tx_overflow;
  int          pass_cnt = 0, total_cnt = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .prog_done(prog_done), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // One bus access: drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic access(input logic [31:0] a, input logic [7:0] d, input logic w);
    mem_a = a; mem_dout = d; mem_wr = w;
    @(negedge clk_in);
    mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    total_cnt++; if (mem_din !== 8'h00) $display("FAIL reset_mem_din got %h want 00", mem_din); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL reset_io_full got %b want 0", io_buffer_full); else pass_cnt++;
    total_cnt++; if ({rx_pop, prog_done, tx_overflow} !== 3'b000) $display("FAIL reset_flags got %b want 000", {rx_pop, prog_done, tx_overflow}); else pass_cnt++;
    rst_n_in = 1'b1;
  endtask

  task automatic test_ram;
    access(32'h0000_0010, 8'h3C, 1'b1);
    access(32'h0000_0010, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h3C) $display("FAIL ram_rd10 got %h want 3c", mem_din); else pass_cnt++;
    access(32'h0000_0123, 8'hA5, 1'b1);
    total_cnt++; if (mem_din !== 8'h3C) $display("FAIL ram_hold_on_wr got %h want 3c", mem_din); else pass_cnt++;
    access(32'h0000_0123, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'hA5) $display("FAIL ram_wr_then_rd got %h want a5", mem_din); else pass_cnt++;
    access(32'hFFFC_0123, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'hA5) $display("FAIL ram_upper_ignored got %h want a5", mem_din); else pass_cnt++;
    access(32'h0001_0123, 8'h11, 1'b1);
    access(32'h0003_0123, 8'h77, 1'b1);
    access(32'h0001_0123, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h11) $display("FAIL io_no_ram_effect got %h want 11", mem_din); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL other_io_wr_ignored tx_valid got %b want 0", tx_valid); else pass_cnt++;
  endtask

  task automatic test_tx_basic;
    tx_ready = 1'b0;
    access(32'h0003_0000, 8'h48, 1'b1);
    access(32'h0003_0000, 8'h69, 1'b1);
    access(32'h0003_0000, 8'h00, 1'b1);
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL tx_valid_after_push got %b want 1", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h48) $display("FAIL tx_head got %h want 48", tx_data); else pass_cnt++;
    tx_ready = 1'b1;
    @(negedge clk_in);
    total_cnt++; if (tx_data !== 8'h69 || tx_valid !== 1'b1) $display("FAIL tx_second got %h/%b want 69/1", tx_data, tx_valid); else pass_cnt++;
    @(negedge clk_in);
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_drained got %b want 0 (zero byte not filtered?)", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_full;
    logic [7:0] exp_q [16];
    tx_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      access(32'h0003_0000, 8'(k), 1'b1);
      total_cnt++; if (io_buffer_full !== (k >= 14)) $display("FAIL io_full_at_%0d got %b want %b", k, io_buffer_full, (k >= 14)); else pass_cnt++;
    end
    tx_ready = 1'b1;
    access(32'h0003_0000, 8'h55, 1'b1);
    tx_ready = 1'b0;
    total_cnt++; if (tx_overflow !== 1'b0) $display("FAIL push_pop_full_overflow got %b want 0", tx_overflow); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h02 || io_buffer_full !== 1'b1) $display("FAIL push_pop_full got %h/%b want 02/1", tx_data, io_buffer_full); else pass_cnt++;
    access(32'h0003_0000, 8'h99, 1'b1);
    total_cnt++; if (tx_overflow !== 1'b1) $display("FAIL overflow_set got %b want 1", tx_overflow); else pass_cnt++;
    for (int i = 0; i < 15; i++) exp_q[i] = 8'(i + 2);
    exp_q[15] = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (tx_data !== exp_q[i] || tx_valid !== 1'b1) $display("FAIL drain_%0d got %h/%b want %h/1", i, tx_data, tx_valid, exp_q[i]); else pass_cnt++;
      @(negedge clk_in);
    end
    total_cnt++; if (tx_valid !== 1'b0 || tx_overflow !== 1'b1) $display("FAIL drain_end got %b/%b want 0/1", tx_valid, tx_overflow); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_rx;
    rx_valid = 1'b1; rx_data = 8'h37;
    access(32'h0003_0000, 8'h00, 1'b0);
    rx_valid = 1'b0;
    total_cnt++; if (mem_din !== 8'h37 || rx_pop !== 1'b1) $display("FAIL rx_read got %h/%b want 37/1", mem_din, rx_pop); else pass_cnt++;
    @(negedge clk_in);
    total_cnt++; if (rx_pop !== 1'b0) $display("FAIL rx_pop_pulse got %b want 0", rx_pop); else pass_cnt++;
    access(32'h0000_0123, 8'h00, 1'b0);
    access(32'h0003_0000, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) $display("FAIL rx_empty got %h/%b want 00/0", mem_din, rx_pop); else pass_cnt++;
    access(32'h0000_0123, 8'h00, 1'b0);
    access(32'h0003_0008, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h00) $display("FAIL other_io_read got %h want 00", mem_din); else pass_cnt++;
  endtask

  task automatic test_snapshot;
    logic [7:0] exp_b [4];
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (254) @(negedge clk_in);
    access(32'h0003_0004, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'hFE) $display("FAIL cyc_after_254 got %h want fe", mem_din); else pass_cnt++;
    access(32'h0003_0005, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h00) $display("FAIL snap_byte1 got %h want 00", mem_din); else pass_cnt++;
    exp_b = '{8'hFE, 8'hFF, 8'hFF, 8'h00};
    force dut.cyc_q = 32'h00FF_FFFE;
    #1 release dut.cyc_q;
    for (int i = 0; i < 4; i++) begin
      access(32'h0003_0004 + 32'(i), 8'h00, 1'b0);
      total_cnt++; if (mem_din !== exp_b[i]) $display("FAIL snap_coherent_%0d got %h want %h", i, mem_din, exp_b[i]); else pass_cnt++;
    end
    @(negedge clk_in);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1 release dut.cyc_q;
    access(32'h0003_0004, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'hFF) $display("FAIL cyc_max got %h want ff", mem_din); else pass_cnt++;
    access(32'h0003_0007, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'hFF) $display("FAIL snap_max_byte3 got %h want ff", mem_din); else pass_cnt++;
    access(32'h0003_0004, 8'h00, 1'b0);
    total_cnt++; if (mem_din !== 8'h01) $display("FAIL cyc_wrapped got %h want 01", mem_din); else pass_cnt++;
  endtask

  task automatic test_prog_done_reset;
    tx_ready = 1'b0;
    access(32'h0003_0000, 8'h41, 1'b1);
    access(32'h0003_0000, 8'h42, 1'b1);
    total_cnt++; if (prog_done !== 1'b0) $display("FAIL prog_done_early got %b want 0", prog_done); else pass_cnt++;
    access(32'h0003_0004, 8'h42, 1'b1);
    total_cnt++; if (prog_done !== 1'b1) $display("FAIL prog_done_set got %b want 1", prog_done); else pass_cnt++;
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
    access(32'h0003_0000, 8'h00, 1'b0);
    total_cnt++; if (tx_data !== 8'h42 || mem_din !== 8'h5A || rx_pop !== 1'b1) $display("FAIL mid_drain got %h/%h/%b want 42/5a/1", tx_data, mem_din, rx_pop); else pass_cnt++;
    access(32'h0003_0000, 8'h00, 1'b0);
    total_cnt++; if (tx_data !== 8'h00 || tx_valid !== 1'b1) $display("FAIL stop_byte got %h/%b want 00/1", tx_data, tx_valid); else pass_cnt++;
    #2 rst_n_in = 1'b0;
    #1;
    total_cnt++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) $display("FAIL async_reset_rd got %h/%b want 00/0", mem_din, rx_pop); else pass_cnt++;
    total_cnt++; if ({tx_valid, io_buffer_full, prog_done, tx_overflow} !== 4'b0000) $display("FAIL async_reset_flags got %b want 0000", {tx_valid, io_buffer_full, prog_done, tx_overflow}); else pass_cnt++;
    tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset;
    test_ram;
    test_tx_basic;
    test_full;
    test_rx;
    test_snapshot;
    test_prog_done_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
